// File: rtl/fp_add_issue.sv
// Issue/capture controller for the fixed-latency, non-stallable fp_add pipeline.
// Optional perf counters (perf_issued, perf_stall) are enabled with FP_ADD_ISSUE_PERF_EN.
module fp_add_issue #(
    parameter int LATENCY    = 11,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fp_dataa,
    output logic [31:0]      fp_datab,
    input  logic [31:0]      fp_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
`ifdef FP_ADD_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W   = $clog2(LATENCY + 1);
    localparam int ENTRY_W = 32 + TAG_W;

    // Both channels: a transfer happens on a clock edge where valid and ready are
    // both high; ready never looks at valid, and valid never waits on ready.
    logic                fire;
    logic                capture;
    logic                pop;
    logic [LATENCY-1:0]  pipe_valid;
    logic [TAG_W-1:0]    pipe_tag [LATENCY];
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic [INF_W-1:0]    inflight;
    logic [31:0]         used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A request is only accepted when a FIFO slot is reserved for its result.
    assign used      = 32'(fifo_count) + 32'(inflight);
    assign req_ready = (used < 32'(FIFO_DEPTH));
    assign fire      = req_valid & req_ready;
    assign fp_dataa  = req_a;
    assign fp_datab  = req_b;
    assign capture   = pipe_valid[LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign busy      = (inflight != '0) | rsp_valid;
    assign {rsp_result, rsp_tag} = rsp_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= fire;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Tags need no reset: they are only consumed when the matching valid bit is set.
    always_ff @(posedge clock) begin
        pipe_tag[0] <= req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
        if (capture) begin
            mem[wr_ptr] <= {fp_result, pipe_tag[LATENCY-1]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            if (capture && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !capture) fifo_count <= fifo_count - CNT_W'(1);
            if (fire && !capture)      inflight <= inflight + INF_W'(1);
            else if (capture && !fire) inflight <= inflight - INF_W'(1);
        end
    end

    no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(capture && fifo_count == CNT_W'(FIFO_DEPTH)));

`ifdef FP_ADD_ISSUE_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (fire && perf_issued != 32'hFFFF_FFFF)
                perf_issued <= perf_issued + 32'd1;
            if (req_valid && !req_ready && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_issue.sv
// Directed bench for fp_add_issue with an integer-exact fp_add model and an in-order scoreboard.
// Perf counter checks are compiled in when FP_ADD_ISSUE_PERF_EN is defined.
module tb_fp_add_issue;

    localparam int LAT   = 11;
    localparam int TW    = 8;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [TW-1:0] req_tag;
    logic [31:0]   fp_dataa;
    logic [31:0]   fp_datab;
    logic [31:0]   fp_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic [TW-1:0] rsp_tag;
    logic          busy;
`ifdef FP_ADD_ISSUE_PERF_EN
    logic [31:0]   perf_issued;
    logic [31:0]   perf_stall;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int fires     = 0;
    int stalls    = 0;
    logic [31:0]      exp_res;
    logic [TW+31:0]   exp_q[$];
    logic [31:0]      fp_pipe [LAT];

    always #5 clock = ~clock;

    fp_add_issue #(.LATENCY(LAT), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .fp_dataa   (fp_dataa),
        .fp_datab   (fp_datab),
        .fp_result  (fp_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
`ifdef FP_ADD_ISSUE_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall (perf_stall)
`endif
    );

    // Exact for non-negative integer-valued floats below 2^24.
    function automatic logic [31:0] f2i(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:23] == 8'd0) return 32'd0;
        e = int'(f[30:23]) - 127;
        m = {8'd0, 1'b1, f[22:0]};
        if (e < 0 || e > 30) return 32'd0;
        if (e >= 23) return m << (e - 23);
        return m >> (23 - e);
    endfunction

    function automatic logic [31:0] i2f(input logic [31:0] n);
        int p;
        logic [31:0] m;
        if (n == 32'd0) return 32'd0;
        p = 0;
        for (int k = 0; k < 32; k++) if (n[k]) p = k;
        m = (p >= 23) ? (n >> (p - 23)) : (n << (23 - p));
        return {1'b0, 8'(p + 127), m[22:0]};
    endfunction

    // fp_add stand-in: fixed latency, never stalls, not reset.
    always @(posedge clock) begin
        fp_pipe[0] <= i2f(f2i(fp_dataa) + f2i(fp_datab));
        for (int i = 1; i < LAT; i++) fp_pipe[i] <= fp_pipe[i-1];
    end
    assign fp_result = fp_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Account the current cycle's handshakes, then advance to 1ns after the next edge.
    task automatic tick();
        logic [TW+31:0] e;
        if (reset_n) begin
            if (req_valid && req_ready) begin
                fires++;
                exp_q.push_back({exp_res, req_tag});
            end
            if (req_valid && !req_ready) stalls++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected_q_size", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data_tag", {rsp_result, rsp_tag}, e);
                end
            end
        end
        @(posedge clock);
        #1;
`ifdef FP_ADD_ISSUE_PERF_EN
        chk("perf_issued", perf_issued, 64'(fires));
        chk("perf_stall", perf_stall, 64'(stalls));
`endif
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag, input logic [31:0] res);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        exp_res   = res;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        exp_res   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        // Single op: 1.0 + 2.0, response exactly 12 cycles after fire.
        drive(32'h3F80_0000, 32'h4000_0000, 8'd3, 32'h4040_0000);
        chk("single_req_ready", req_ready, 1);
        chk("single_dataa", fp_dataa, 32'h3F80_0000);
        chk("single_datab", fp_datab, 32'h4000_0000);
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < 12; k++) begin
            chk("single_busy", busy, 1);
            chk("single_early_valid", rsp_valid, 0);
            tick();
        end
        chk("single_valid", rsp_valid, 1);
        chk("single_result", rsp_result, 32'h4040_0000);
        chk("single_tag", rsp_tag, 8'd3);
        chk("single_busy_last", busy, 1);
        tick();
        chk("single_valid_after", rsp_valid, 0);
        chk("single_busy_after", busy, 0);

        // Streaming: 32 back-to-back requests i + 1.0.
        for (int cyc = 0; cyc < 48; cyc++) begin
            if (cyc < 32) begin
                drive(i2f(32'(cyc)), 32'h3F80_0000, TW'(cyc % 16), i2f(32'(cyc + 1)));
                chk("stream_req_ready", req_ready, 1);
            end else begin
                req_valid = 1'b0;
            end
            chk("stream_rsp_window", rsp_valid, (cyc >= 12 && cyc < 44));
            tick();
        end
        chk("stream_all_returned", 64'(exp_q.size()), 0);

        // Backpressure: consumer stalled, producer keeps pushing.
        rsp_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            drive(i2f(32'(100 + k)), 32'h3F80_0000, TW'(k), i2f(32'(101 + k)));
            chk("bp_req_ready", req_ready, (k < 16));
            tick();
        end
        req_valid = 1'b0;
        chk("bp_queued", 64'(exp_q.size()), 16);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_busy", busy, 1);
        rsp_ready = 1'b1;
        chk("bp_ready_before_pop", req_ready, 0);
        tick();
        chk("bp_ready_after_pop", req_ready, 1);
        for (int j = 1; j < 16; j++) begin
            chk("bp_drain_valid", rsp_valid, 1);
            tick();
        end
        chk("bp_drained", rsp_valid, 0);
        chk("bp_all_popped", 64'(exp_q.size()), 0);

        // Concurrent capture and pop at count 1, then hold while stalled.
        rsp_ready = 1'b0;
        drive(i2f(32'd5), 32'h3F80_0000, 8'h11, 32'h40C0_0000);
        tick();
        drive(i2f(32'd7), 32'h3F80_0000, 8'h22, 32'h4100_0000);
        tick();
        req_valid = 1'b0;
        for (int k = 2; k < 12; k++) tick();
        chk("cc_first_valid", rsp_valid, 1);
        chk("cc_first_result", rsp_result, 32'h40C0_0000);
        rsp_ready = 1'b1;
        tick();
        chk("cc_second_valid", rsp_valid, 1);
        chk("cc_second_result", rsp_result, 32'h4100_0000);
        chk("cc_second_tag", rsp_tag, 8'h22);
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("cc_hold_valid", rsp_valid, 1);
        chk("cc_hold_result", rsp_result, 32'h4100_0000);
        chk("cc_hold_tag", rsp_tag, 8'h22);
        rsp_ready = 1'b1;
        tick();
        chk("cc_empty", rsp_valid, 0);

        // Reset with five operations in flight.
        for (int k = 0; k < 5; k++) begin
            drive(i2f(32'(10 + k)), 32'h3F80_0000, TW'(8'h40 + k), i2f(32'(11 + k)));
            tick();
        end
        req_valid = 1'b0;
        reset_n   = 1'b0;
        exp_q.delete();
        fires     = 0;
        stalls    = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        tick();
        reset_n = 1'b1;
        drive(32'h4040_0000, 32'h4080_0000, 8'h07, 32'h40E0_0000);
        chk("post_rst_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < 15; k++) begin
            chk("post_rst_rsp_window", rsp_valid, (k == 12));
            if (k == 12) begin
                chk("post_rst_result", rsp_result, 32'h40E0_0000);
                chk("post_rst_tag", rsp_tag, 8'h07);
            end
            tick();
        end

        // Full-width tags back to back.
        drive(32'h3F80_0000, 32'h3F80_0000, 8'hA5, 32'h4000_0000);
        tick();
        drive(32'h4000_0000, 32'h4000_0000, 8'h5A, 32'h4080_0000);
        tick();
        req_valid = 1'b0;
        for (int k = 2; k < 16; k++) begin
            chk("tag_rsp_window", rsp_valid, (k == 12 || k == 13));
            if (k == 12) chk("tag_first", rsp_tag, 8'hA5);
            if (k == 13) chk("tag_second", rsp_tag, 8'h5A);
            tick();
        end

        chk("final_queue_empty", 64'(exp_q.size()), 0);
        chk("final_busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
